// File: rtl/sha_host_if.sv
// Host-side bundle for sha_host: byte stream in, message array and start pulse to the
// core, digest in from the core, byte stream out.
interface sha_host_if #(
    parameter int unsigned Nl = 64,
    parameter int unsigned Nk = 256
);
    logic                   In_Valid;
    logic                   In_Ready;
    logic [7:0]             In_Data;
    logic [0:Nl-1][7:0]     Msg;
    logic                   Start;
    logic [Nk-1:0]          Hash_In;
    logic                   Hash_Valid;
    logic [7:0]             Out_Data;
    logic                   Out_Valid;
    logic                   Out_Ready;
    logic                   Out_Last;
    logic                   Error;

    // Environment side: byte producer, SHA core and byte consumer.
    modport master (
        output In_Valid, In_Data, Hash_In, Hash_Valid, Out_Ready,
        input  In_Ready, Msg, Start, Out_Data, Out_Valid, Out_Last, Error
    );

    // sha_host side.
    modport slave (
        input  In_Valid, In_Data, Hash_In, Hash_Valid, Out_Ready,
        output In_Ready, Msg, Start, Out_Data, Out_Valid, Out_Last, Error
    );
endinterface

// File: rtl/sha_host.sv
// Request/response sequencer in front of a SHA core: loads Nl message bytes, pulses Start,
// waits for the digest and streams it out MSB first. Watchdog built with SHA_HOST_TIMEOUT_EN.
module sha_host #(
    parameter int unsigned Nl      = 64,
    parameter int unsigned Nk      = 256,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic       clk,
    input logic       rst,
    sha_host_if.slave bus
);
    localparam int unsigned NB    = Nk / 8;
    localparam int unsigned CntW  = (Nl > 1) ? $clog2(Nl) : 1;
    localparam int unsigned OcntW = (NB > 1) ? $clog2(NB) : 1;

    // Elaboration-time guard on the configuration.
    if ((Nk != 160 && Nk != 256 && Nk != 512) || Nl < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("sha_host: unsupported Nl/Nk/TIMEOUT");
    end

    typedef enum logic [1:0] {StLoad, StStart, StWait, StSend} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [OcntW-1:0]   ocnt_q, ocnt_d;
    logic [Nk-1:0]      hreg_q, hreg_d;
    logic [0:Nl-1][7:0] msg_q, msg_d;
    logic               timeout_hit;
    logic [Nk-1:0]      hshift;

`ifdef SHA_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wcnt_q;
    logic          err_q;

    assign timeout_hit = (state_q == StWait) && !bus.Hash_Valid &&
                         (wcnt_q == TW'(TIMEOUT - 1));

    // Held at zero outside WAIT so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= timeout_hit;
            wcnt_q <= (state_q == StWait) ? wcnt_q + 1'b1 : '0;
        end
    end

    assign bus.Error = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.Error   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ocnt_d  = ocnt_q;
        hreg_d  = hreg_q;
        msg_d   = msg_q;
        unique case (state_q)
            StLoad: begin
                if (bus.In_Valid) begin
                    msg_d[cnt_q] = bus.In_Data;
                    if (cnt_q == CntW'(Nl - 1)) begin
                        cnt_d   = '0;
                        state_d = StStart;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                // A digest arriving on the timeout cycle still wins.
                if (bus.Hash_Valid) begin
                    hreg_d  = bus.Hash_In;
                    state_d = StSend;
                end else if (timeout_hit) begin
                    state_d = StLoad;
                end
            end
            StSend: begin
                if (bus.Out_Ready) begin
                    if (ocnt_q == OcntW'(NB - 1)) begin
                        ocnt_d  = '0;
                        state_d = StLoad;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            ocnt_q  <= '0;
            hreg_q  <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            hreg_q  <= hreg_d;
            msg_q   <= msg_d;
        end
    end

    // Byte ocnt of the digest lands in the top byte after shifting left by 8*ocnt.
    assign hshift = hreg_q << {ocnt_q, 3'b000};

    assign bus.In_Ready  = (state_q == StLoad);
    assign bus.Start     = (state_q == StStart);
    assign bus.Out_Valid = (state_q == StSend);
    assign bus.Out_Last  = (state_q == StSend) && (ocnt_q == OcntW'(NB - 1));
    assign bus.Out_Data  = (state_q == StSend) ? hshift[Nk-1 -: 8] : 8'h00;
    assign bus.Msg       = msg_q;
endmodule

// File: tb/tb_sha_host.sv
// Randomized scoreboard bench for sha_host: the bench plays byte producer, SHA core and
// byte consumer; a monitor checks Msg at Start and every digest byte against queued models.
module tb_sha_host;
    localparam int unsigned Nl      = 3;
    localparam int unsigned Nk      = 256;
    localparam int unsigned NB      = Nk / 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sha_host_if #(.Nl(Nl), .Nk(Nk)) bus ();

    sha_host #(.Nl(Nl), .Nk(Nk), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8*Nl-1:0] msg_exp_q[$];
    logic [8:0]      out_exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Consumer with random backpressure.
    initial begin
        bus.Out_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.Out_Ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor / scoreboard.
    logic       prev_start = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic       turn_chk   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            stall_prev = 1'b0;
            turn_chk   = 1'b0;
        end else begin
            if (turn_chk) check("turnaround_in_ready", bus.In_Ready, 1);
            turn_chk = 1'b0;
            if (bus.Start) begin
                check("start_one_cycle", prev_start, 0);
                if (msg_exp_q.size() == 0) fail_now("start_unexpected");
                else check("msg_at_start", bus.Msg, msg_exp_q.pop_front());
            end
            prev_start = bus.Start;
            if (bus.Out_Valid) begin
                if (stall_prev) begin
                    check("hold_out_data", bus.Out_Data, prev_data);
                    check("hold_out_last", bus.Out_Last, prev_last);
                end
                if (bus.Out_Ready) begin
                    if (out_exp_q.size() == 0) begin
                        fail_now("out_unexpected");
                    end else begin
                        logic [8:0] e;
                        e = out_exp_q.pop_front();
                        check("out_byte", {bus.Out_Last, bus.Out_Data}, e);
                        if (e[8]) turn_chk = 1'b1;
                    end
                end
            end
            stall_prev = bus.Out_Valid && !bus.Out_Ready;
            prev_data  = bus.Out_Data;
            prev_last  = bus.Out_Last;
`ifndef SHA_HOST_TIMEOUT_EN
            if (bus.Error) fail_now("error_without_watchdog");
`endif
        end
    end

    task automatic wait_in_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.In_Ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now(name);
    endtask

    // Streams msg MSB-first with random gaps, then holds In_Valid high with junk and
    // checks the Start pulse lands one cycle after the last byte.
    task automatic load_msg(input logic [8*Nl-1:0] msg);
        logic [8*Nl-1:0] tmp;
        tmp = msg;
        msg_exp_q.push_back(msg);
        for (int i = 0; i < int'(Nl); i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                bus.In_Valid = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.In_Valid = 1'b1;
            bus.In_Data  = tmp[8*Nl-1 -: 8];
            tmp = tmp << 8;
        end
        @(posedge clk);
        #1;
        bus.In_Data = 8'($urandom);
        @(negedge clk);
        check("start_after_last_byte", bus.Start, 1);
        check("in_ready_low_in_start", bus.In_Ready, 0);
    endtask

    logic [Nk-1:0]   abc_digest;
    logic [Nk-1:0]   dig;
    logic [Nk-1:0]   tmpd;
    logic [8*Nl-1:0] msg;
    logic [7:0]      b;

    initial begin
        #3_000_000;
        fail_now("global_time_limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        abc_digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        bus.In_Valid   = 1'b0;
        bus.In_Data    = 8'h00;
        bus.Hash_In    = '0;
        bus.Hash_Valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", bus.In_Ready, 1);
        check("reset_start", bus.Start, 0);
        check("reset_out_valid", bus.Out_Valid, 0);
        check("reset_out_last", bus.Out_Last, 0);
        check("reset_out_data", bus.Out_Data, 0);
        check("reset_error", bus.Error, 0);
        check("reset_msg", bus.Msg, 0);

        // Stray digest while loading must be ignored.
        @(posedge clk);
        #1;
        bus.Hash_Valid = 1'b1;
        bus.Hash_In    = {8{$urandom}};
        @(posedge clk);
        #1;
        bus.Hash_Valid = 1'b0;
        @(negedge clk);
        check("stray_hash_out_valid", bus.Out_Valid, 0);
        check("stray_hash_in_ready", bus.In_Ready, 1);

        for (int m = 0; m < 8; m++) begin
            wait_in_ready("wait_load");
            if (m == 0) begin
                msg = 24'h616263;
                dig = abc_digest;
            end else begin
                msg = 24'($urandom);
                dig = {8{$urandom}};
            end
            load_msg(msg);
            // Core busy: junk on the input side must not reach Msg.
            repeat ($urandom_range(1, 6)) begin
                @(posedge clk);
                #1;
                bus.In_Valid = 1'b1;
                bus.In_Data  = 8'($urandom);
            end
            @(negedge clk);
            check("msg_hold_in_wait", bus.Msg, msg);
            @(posedge clk);
            #1;
            bus.In_Valid   = 1'b0;
            bus.Hash_Valid = 1'b1;
            bus.Hash_In    = dig;
            tmpd = dig;
            for (int i = 0; i < int'(NB); i++) begin
                b = tmpd[Nk-1 -: 8];
                tmpd = tmpd << 8;
                out_exp_q.push_back({(i == int'(NB) - 1), b});
            end
            @(posedge clk);
            #1;
            bus.Hash_Valid = 1'b0;
            bus.Hash_In    = {8{$urandom}};
            @(negedge clk);
            check("digest_to_out_valid", bus.Out_Valid, 1);
            for (int i = 0; i < 2000 && out_exp_q.size() != 0; i++) @(negedge clk);
            if (out_exp_q.size() != 0) fail_now("digest_drain");
        end

        // Reset while the core is still working.
        wait_in_ready("wait_load_rst");
        load_msg(24'($urandom));
        @(posedge clk);
        #1;
        bus.In_Valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_in_ready", bus.In_Ready, 1);
        check("rst_wait_msg_clear", bus.Msg, 0);
        check("rst_wait_out_valid", bus.Out_Valid, 0);
        @(posedge clk);
        #1;
        bus.Hash_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus.Hash_Valid = 1'b0;
        @(negedge clk);
        check("late_hash_ignored", bus.Out_Valid, 0);

`ifdef SHA_HOST_TIMEOUT_EN
        // Withheld digest: Error pulses TIMEOUT cycles after WAIT entry.
        load_msg(24'($urandom));
        @(posedge clk);
        #1;
        bus.In_Valid = 1'b0;
        for (int i = 0; i <= int'(TIMEOUT) + 1; i++) begin
            @(negedge clk);
            check("timeout_error", bus.Error, (i == int'(TIMEOUT)));
            if (i == int'(TIMEOUT)) check("timeout_in_ready", bus.In_Ready, 1);
        end
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha_host.md
# sha_host

Initiator-side companion to the SHA core top. It accepts a message as a byte stream with a valid/ready handshake and assembles it into the core's Nl-byte `Data` array. It then pulses the core's `Enable` and waits for the core's `Ready`. It captures the digest and returns it as a byte stream, most significant byte first. It sits between a byte-oriented host bus and the SHA core and owns the whole request/response sequence.

## Interface
Parameters:
- `Nl`, 64: message length in bytes. Must match the core's `Nl`. Range ≥ 1.
- `Nk`, 256: digest width in bits. Must be one of 160, 256 or 512, matching the core.
- `TIMEOUT`, 4096: watchdog limit in cycles. Used only with `SHA_HOST_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `In_Data`, in, 8: message byte.
- `In_Valid`, in, 1: `In_Data` is valid.
- `In_Ready`, out, 1: the block accepts a byte this cycle.
- `Msg`, out, 8 × [0:Nl-1]: message array. Connects to the core's `Data`.
- `Start`, out, 1: one-cycle request pulse. Connects to the core's `Enable`.
- `Hash_In`, in, Nk: digest from the core's `Hash`.
- `Hash_Valid`, in, 1: connects to the core's `Ready`.
- `Out_Data`, out, 8: digest byte.
- `Out_Valid`, out, 1: `Out_Data` is valid.
- `Out_Ready`, in, 1: the consumer accepts the byte.
- `Out_Last`, out, 1: marks the final digest byte.
- `Error`, out, 1: one-cycle watchdog pulse. Tied to 0 without `SHA_HOST_TIMEOUT_EN`.

## Operation
- States: LOAD, START, WAIT, SEND. Reset state is LOAD.
- LOAD:
  - `In_Ready`=1.
  - On `In_Valid && In_Ready`, write `Msg[cnt] <= In_Data` and increment `cnt`.
  - When the byte with `cnt==Nl-1` is accepted, go to START and clear `cnt`.
- START:
  - `Start`=1 for exactly one cycle.
  - Next state is WAIT unconditionally.
- WAIT:
  - Hold `Msg` stable; the core reads it across several blocks.
  - On `Hash_Valid`=1, latch `Hash_In` into the digest register `hreg` and go to SEND.
- SEND:
  - `Out_Valid`=1 and `Out_Data = hreg[Nk-1-8*ocnt -: 8]`, so byte 0 is the MSB.
  - `Out_Last` = (`ocnt == Nk/8-1`).
  - On `Out_Ready`, increment `ocnt`.
  - When the last byte is accepted, go to LOAD and clear `ocnt`.
- `Msg` may only be written in LOAD. It keeps its value in every other state and is not cleared between messages.
- `Hash_Valid` outside WAIT is ignored; `hreg` is unchanged.
- `In_Valid` outside LOAD is ignored; no byte is consumed.
- Counter widths:
  - `cnt` is $clog2(Nl) bits.
  - `ocnt` is $clog2(Nk/8) bits.
  - Neither counter wraps during normal operation; each is cleared on its terminal transition.
- Reset mid-operation:
  - Aborts any state and returns to LOAD.
  - Clears `cnt`, `ocnt`, `hreg` and `Msg`.
  - A core that is still hashing is not told. Its late `Hash_Valid` falls in LOAD and is ignored.

## Timing
- Values while `rst`=1 and in the first cycle after it deasserts:
  - Registers: state LOAD, `Msg` all 0x00, `hreg`=0.
  - Outputs: `In_Ready`=1, `Start`=0, `Out_Valid`=0, `Out_Last`=0, `Out_Data`=0x00, `Error`=0.
- Outputs are decoded from registered state only. No combinational path exists from any input to any output.
- Throughput: one byte per cycle in both directions when the partner keeps its valid/ready high.
- Input to request latency: if the final byte is accepted in cycle N, `Start`=1 in N+1 and WAIT begins in N+2.
- Digest to output latency: if `Hash_Valid` is seen in cycle M, `Out_Valid`=1 in M+1.
- Output backpressure: while `Out_Valid && !Out_Ready`, `Out_Data` and `Out_Last` hold stable.
- Turnaround: if the last output byte is accepted in cycle K, `In_Ready`=1 in K+1.
- Total overhead per message: Nl + 2 + core latency + Nk/8 + 1 cycles, with no stalls.

## Configuration
- `SHA_HOST_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `Hash_Valid` has not arrived after `TIMEOUT` cycles in WAIT, `Error`=1 for one cycle and the state returns to LOAD. `hreg` is untouched.
  - The counter clears whenever WAIT is entered.
- `SHA_HOST_TIMEOUT_EN` undefined:
  - No counter is built and `Error` is constant 0.
  - WAIT waits indefinitely.

## Test plan
- Reset: after `rst` high for 3 cycles then low, expect `In_Ready`=1, `Start`=0, `Out_Valid`=0 and all `Msg` = 0x00.
- Load and request (Nl=3, Nk=256): stream 0x61, 0x62, 0x63 with `In_Valid` held high.
  - Expect `Msg` = {61,62,63}.
  - Expect `Start`=1 exactly one cycle after the third byte, and `In_Ready`=0 from then on.
- Digest return (Nl=3, Nk=256, real core): run the "abc" message through the core.
  - Expect 32 output bytes, beginning BA 78 16 BF and ending F2 00 15 AD.
  - Expect `Out_Last`=1 only on byte 31.
- Backpressure: toggle `Out_Ready` pseudo-randomly.
  - `Out_Data` and `Out_Last` must never change while `Out_Valid && !Out_Ready`.
  - The byte order must be identical to the unstalled case.
- Stray inputs:
  - Pulse `Hash_Valid` while in LOAD: no state change and `hreg` unchanged.
  - Drive `In_Valid` during WAIT: `Msg` unchanged.
- Reset mid-WAIT, then timeout (with `SHA_HOST_TIMEOUT_EN`, TIMEOUT=16):
  - Assert `rst` during WAIT: expect LOAD next cycle with `Msg` cleared.
  - Start a new message and withhold `Hash_Valid`: expect `Error`=1 exactly 16 cycles after WAIT entry, then `In_Ready`=1.
